ram_bus_master: RTL
===================

// Module: ram_bus_master
// PURPOSE
//   Initiator side of the RAM's shared tri-state data bus. Takes single-word writes and 1..16-word
//   incrementing burst reads from the CPU/loader over a valid/ready request port. Drives the RAM's
//   address, write_enable and read_enable pins and the inout data bus. Returns read data as a
//   non-backpressured response stream. Sits between the control unit and the 16x8 RAM.
// PARAMETERS
//   ADDR_WIDTH  4  RAM address width; req_len is also ADDR_WIDTH bits wide (max 2**ADDR_WIDTH beats)
//   DATA_WIDTH  8  RAM word width
// PORTS
//   clk               in     1           single clock, all logic on posedge
//   rst_n             in     1           asynchronous active-low reset
//   req_valid         in     1           request present
//   req_ready         out    1           request accepted when req_valid & req_ready at posedge
//   req_write         in     1           1 = single write, 0 = burst read
//   req_addr          in     ADDR_WIDTH  start address
//   req_len           in     ADDR_WIDTH  read beats minus 1 (0 = 1 word, 15 = 16 words); ignored on write
//   req_wdata         in     DATA_WIDTH  write data
//   rsp_valid         out    1           read beat valid (one cycle per beat, no backpressure)
//   rsp_data          out    DATA_WIDTH  read data
//   rsp_last          out    1           final beat of burst, qualified by rsp_valid
//   busy              out    1           ~req_ready
//   mem_addr          out    ADDR_WIDTH  to RAM address
//   mem_write_enable  out    1           to RAM write_enable
//   mem_read_enable   out    1           to RAM read_enable
//   mem_data          inout  DATA_WIDTH  RAM data bus; driven only in WR state, else high-Z
// BEHAVIOUR
//   Reset (async, immediate): state IDLE, req_ready=1 after release; mem_addr=0; mem_write_enable=0;
//     mem_read_enable=0; mem_data=Z; rsp_valid=0; rsp_last=0; rsp_data=0; beat counters=0.
//     Reset mid-burst or mid-write aborts the transaction. No further rsp beats are produced.
//   RAM contract: write on posedge when we&~re. Otherwise the RAM latches M[addr] into its buffer each
//     posedge. It drives the bus combinationally while re&~we.
//   FSM states: IDLE -> WR -> IDLE; IDLE -> RD -> IDLE. req_ready=1 only in IDLE.
//     All mem_* outputs are registered or decoded purely from the state register (no req_* paths).
//   IDLE: we=0, re=0, bus Z. Request fields are captured at the acceptance edge E0.
//     Request fields are ignored at all other times.
//   WR (exactly 1 cycle after E0): mem_addr=A, we=1, re=0, mem_data=D.
//     The RAM writes at edge E1. Then IDLE, so req_ready=1 in the second cycle after E0. No rsp beat.
//   RD (cycle after E0 up to the last capture): re=1 continuously for len+2 cycles, we=0.
//     mem_addr steps A, A+1, ... one per cycle for len+1 cycles, wrapping mod 2**ADDR_WIDTH (15->0).
//     After that it holds the last address.
//     Capture starts at the 2nd edge after E0: each posedge samples mem_data into rsp_data.
//     Beat k (k=0..len) has rsp_valid=1 in cycle E0+3+k, data=M[(A+k) mod 16].
//     rsp_valid stays high for len+1 consecutive cycles.
//     rsp_last=1 only on beat len. The FSM enters IDLE on the last capture edge,
//     so req_ready=1 in the same cycle as rsp_last.
//   Back-to-back: a request accepted in the rsp_last cycle is legal.
//     re drops on the same edge that any following WR raises we and drives the bus.
//   Invariants: mem_write_enable & mem_read_enable never both 1.
//     mem_data driven only when we=1 & re=0. rsp_valid=0 outside RD completion.
//   Widths: address increment and beat counter are ADDR_WIDTH-bit modular.
//     Beat count len+1 uses an ADDR_WIDTH+1-bit compare so that len=15 yields 16 beats.
// TESTING
//   1 Reset: assert rst_n=0 during a 16-beat read at beat 5 -> same-cycle re=0, we=0, bus Z,
//     rsp_valid=0. After release: req_ready=1 and no stray beats.
//   2 Write A=3 D=0xA5, then read A=3 len=0 -> we=1 for exactly 1 cycle with addr 3/data A5.
//     Read gives one beat rsp_data=0xA5, rsp_last=1, 3 cycles after acceptance.
//   3 RAM preset M[i]=i; read A=14 len=3 -> mem_addr 14,15,0,1; rsp_data 0x0E,0x0F,0x00,0x01
//     on consecutive cycles, rsp_last on 0x01.
//   4 Read A=0 len=15 -> 16 consecutive beats 0x00..0x0F. re high for 17 cycles. req_ready=1 with rsp_last.
//   5 New write A=9 D=0x3C accepted in the rsp_last cycle -> no cycle with re&we, bus never X,
//     M[9]=0x3C afterwards.
//   6 req_valid held with changing fields while busy -> nothing accepted.
//     The in-flight burst data is unaffected.

Source files
------------

// File: rtl/ram_bus_master.sv
// Initiator for the RAM's shared tri-state data bus: single-word writes and
// 1..2**ADDR_WIDTH-beat incrementing burst reads, with a non-backpressured response stream.
module ram_bus_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ADDR_WIDTH-1:0] req_len,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] len;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                  state_q, state_d;
    req_t                    req_q, req_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_last_q, rsp_last_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic [ADDR_WIDTH:0]     len_ext;
    logic [ADDR_WIDTH:0]     last_cnt;

    // cnt counts RD cycles; one extra bit so len=max still reaches len+1
    assign len_ext  = {1'b0, req_q.len};
    assign last_cnt = len_ext + 1'b1;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    cnt_d  = '0;
                    if (req_write) begin
                        req_d.wdata = req_wdata;
                        state_d     = S_WR;
                    end else begin
                        req_d.len = req_len;
                        state_d   = S_RD;
                    end
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_RD: begin
                // Address leads capture by two edges: RAM buffers on one edge, we sample on the next
                if (cnt_q < len_ext) begin
                    addr_d = addr_q + 1'b1;
                end
                if (cnt_q != '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mem_data;
                    rsp_last_d  = (cnt_q == last_cnt);
                end
                if (cnt_q == last_cnt) begin
                    state_d = S_IDLE;
                end
                cnt_d = cnt_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready        = (state_q == S_IDLE);
    assign busy             = ~req_ready;
    assign mem_addr         = addr_q;
    assign mem_write_enable = (state_q == S_WR);
    assign mem_read_enable  = (state_q == S_RD);
    assign mem_data         = mem_write_enable ? req_q.wdata : {DATA_WIDTH{1'bz}};
    assign rsp_valid        = rsp_valid_q;
    assign rsp_last         = rsp_last_q;
    assign rsp_data         = rsp_data_q;

endmodule
